muldiv_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the MULT/MULTU/DIV/DIVU path of the MIPS EX stage.
- Accepts a decoded mul/div request, owns the radix-2 restoring divider and the latched-operand multiplier, and stalls the pipeline until the result is ready.
- Returns {hi, lo} with a one-cycle valid pulse for the HI/LO register write.
- Abandons work on exception flush.

---
 rtl/muldiv_seq_ctrl_pkg.sv | 26 ++
 rtl/muldiv_seq_ctrl_if.sv | 23 ++
 rtl/muldiv_seq_ctrl_div_radix2_core.sv | 66 ++++++
 rtl/muldiv_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_muldiv_seq_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared definitions for the MIPS EX-stage mul/div sequencer.
// The EX stage maps its alucontrol codes onto md_op_e.
package muldiv_seq_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    // Two's-complement magnitude when the operation is signed.
    function automatic logic [XLEN-1:0] abs_mag(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// EX-stage <-> mul/div sequencer request/result bundle.
interface muldiv_seq_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    modport master (
        output start, op, src_a, src_b, flush,
        input  stall, result_valid, hi, lo, busy
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output stall, result_valid, hi, lo, busy
    );
endinterface

// File: rtl/muldiv_seq_ctrl_div_radix2_core.sv
// Radix-2 restoring divider on unsigned magnitudes, one shift-subtract step per cycle.
// quotient/remainder are the combinational result of the step in progress; done marks the last step.
module div_radix2_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [WIDTH:0]   shifted, diff;

    always_comb begin
        shifted   = {rem_q, quo_q[WIDTH-1]};
        diff      = shifted - {1'b0, dvsr_q};
        quotient  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        remainder = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        done      = run_q && (cnt_q == LAST);

        rem_d  = rem_q;
        quo_d  = quo_q;
        dvsr_d = dvsr_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvsr_d = divisor;
            cnt_d  = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            rem_d = remainder;
            quo_d = quotient;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) run_d = 1'b0;
        end
        if (abort) run_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end
endmodule

// File: rtl/muldiv_seq_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer: stalls EX until {hi, lo} is ready, pulses result_valid once.
// Optional MULDIV_DIVZERO_FAST_EN: divide by zero completes in one cycle without starting the divider.
module muldiv_seq_ctrl
    import muldiv_seq_ctrl_pkg::*;
#(
    parameter int MUL_LAT   = 2,
    parameter int DIV_ITERS = 32
) (
    input  logic                clk,
    input  logic                resetn,
    muldiv_seq_ctrl_if.slave    bus
);
    localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

    md_state_e   state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        accept, stall, result_valid;
    logic        core_start, core_done;
    logic [31:0] core_quo, core_rem, quo_fix, rem_fix;
    logic [63:0] mul_a, mul_b, product;
    logic        q_neg, r_neg;

    assign accept = bus.start && !bus.flush;

    always_comb begin
        mul_a   = (op_q == MD_MULT) ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        mul_b   = (op_q == MD_MULT) ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        product = mul_a * mul_b;
        q_neg   = (op_q == MD_DIV) && (a_q[31] ^ b_q[31]);
        r_neg   = (op_q == MD_DIV) && a_q[31];
        // Negation wraps, so 0x80000000 / -1 yields 0x80000000 with no trap.
        quo_fix = q_neg ? (~core_quo + 1'b1) : core_quo;
        rem_fix = r_neg ? (~core_rem + 1'b1) : core_rem;
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        core_start   = 1'b0;
        stall        = 1'b0;
        result_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    stall = 1'b1;
                    op_d  = bus.op;
                    a_d   = bus.src_a;
                    b_d   = bus.src_b;
                    cnt_d = '0;
                    if (!bus.op[1]) begin
                        state_d = ST_MUL;
                    end else begin
`ifdef MULDIV_DIVZERO_FAST_EN
                        if (bus.src_b == '0) begin
                            hi_d    = bus.src_a;
                            lo_d    = '1;
                            state_d = ST_DONE;
                        end else begin
                            core_start = 1'b1;
                            state_d    = ST_DIV;
                        end
`else
                        core_start = 1'b1;
                        state_d    = ST_DIV;
`endif
                    end
                end
            end
            ST_MUL: begin
                stall = 1'b1;
                if (cnt_q == MUL_LAST) begin
                    {hi_d, lo_d} = product;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DIV: begin
                stall = 1'b1;
                if (core_done) begin
                    hi_d    = rem_fix;
                    lo_d    = quo_fix;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // start still high here belongs to the instruction just completed.
                result_valid = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.flush) begin
            state_d      = ST_IDLE;
            stall        = 1'b0;
            result_valid = 1'b0;
            hi_d         = hi_q;
            lo_d         = lo_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    div_radix2_core #(.WIDTH(DIV_ITERS)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (core_start),
        .abort     (bus.flush),
        .dividend  (abs_mag(bus.src_a, bus.op == MD_DIV)),
        .divisor   (abs_mag(bus.src_b, bus.op == MD_DIV)),
        .quotient  (core_quo),
        .remainder (core_rem),
        .done      (core_done)
    );

    assign bus.stall        = stall;
    assign bus.result_valid = result_valid;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed self-checking bench for muldiv_seq_ctrl (MUL_LAT=2, DIV_ITERS=32).
module tb_muldiv_seq_ctrl;
    import muldiv_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    muldiv_seq_ctrl_if md_if();

    muldiv_seq_ctrl #(.MUL_LAT(2), .DIV_ITERS(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (md_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULDIV_DIVZERO_FAST_EN
    localparam int DIVZ_LAT = 1;
`else
    localparam int DIVZ_LAT = 33;
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Holds start from the accept cycle through DONE; lat counts cycles from accept to result_valid.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int maxcyc, output int lat, output int stalls,
                          output logic [31:0] h, output logic [31:0] l);
        md_if.start = 1'b1;
        md_if.op    = o;
        md_if.src_a = a;
        md_if.src_b = b;
        lat = -1; stalls = 0; h = '0; l = '0;
        for (int k = 0; k <= maxcyc; k++) begin
            @(negedge clk);
            if (md_if.stall) stalls++;
            if (md_if.result_valid) begin
                lat = k; h = md_if.hi; l = md_if.lo;
                break;
            end
            tick();
        end
        tick();
        md_if.start = 1'b0;
        $display("op=%0d a=%h b=%h latency=%0d stall_cycles=%0d hi=%h lo=%h", o, a, b, lat, stalls, h, l);
    endtask

    task automatic test_reset;
        md_if.start = 1'b0; md_if.op = 2'b00; md_if.src_a = '0; md_if.src_b = '0; md_if.flush = 1'b0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({md_if.hi, md_if.lo} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo: got %h expected 0", {md_if.hi, md_if.lo}); end
        n_checks++;
        if ({md_if.busy, md_if.stall, md_if.result_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got busy/stall/rv=%b expected 000", {md_if.busy, md_if.stall, md_if.result_valid});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_mult;
        int lat, st; logic [31:0] h, l;
        run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, 10, lat, st, h, l);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL mult_latency: got %0d expected 3", lat); end
        n_checks++; if (st !== 3) begin n_fail++; $display("FAIL mult_stall_cycles: got %0d expected 3", st); end
        n_checks++; if (h !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", h); end
        n_checks++; if (l !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffffa", l); end
        @(negedge clk);
        n_checks++;
        if ({md_if.busy, md_if.result_valid} !== 2'b00) begin
            n_fail++; $display("FAIL done_start_ignored: got busy/rv=%b expected 00", {md_if.busy, md_if.result_valid});
        end
        tick();
    endtask

    task automatic test_multu;
        int lat, st; logic [31:0] h, l;
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 10, lat, st, h, l);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL multu_latency: got %0d expected 3", lat); end
        n_checks++; if ({h, l} !== 64'hFFFFFFFE_00000001) begin n_fail++; $display("FAIL multu_result: got %h expected fffffffe00000001", {h, l}); end
    endtask

    task automatic test_div_signed;
        int lat, st; logic [31:0] h, l;
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 40, lat, st, h, l);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div_latency: got %0d expected 33", lat); end
        n_checks++; if (st !== 33) begin n_fail++; $display("FAIL div_stall_cycles: got %0d expected 33", st); end
        n_checks++; if ({h, l} !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin n_fail++; $display("FAIL div_neg7_2: got %h expected fffffffffffffffd", {h, l}); end
        run_op(MD_DIV, 32'd7, 32'hFFFFFFFE, 40, lat, st, h, l);
        n_checks++; if ({h, l} !== {32'h00000001, 32'hFFFFFFFD}) begin n_fail++; $display("FAIL div_7_neg2: got %h expected 00000001fffffffd", {h, l}); end
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 40, lat, st, h, l);
        n_checks++; if ({h, l} !== {32'h00000000, 32'h80000000}) begin n_fail++; $display("FAIL div_overflow: got %h expected 0000000080000000", {h, l}); end
    endtask

    task automatic test_div_by_zero;
        int lat, st; logic [31:0] h, l;
        run_op(MD_DIVU, 32'd100, 32'd0, 40, lat, st, h, l);
        n_checks++; if (lat !== DIVZ_LAT) begin n_fail++; $display("FAIL divz_latency: got %0d expected %0d", lat, DIVZ_LAT); end
        n_checks++; if ({h, l} !== {32'd100, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL divz_result: got %h expected 00000064ffffffff", {h, l}); end
        run_op(MD_DIVU, 32'd1000, 32'd7, 40, lat, st, h, l);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d expected 33", lat); end
        n_checks++; if ({h, l} !== {32'd6, 32'd142}) begin n_fail++; $display("FAIL divu_result: got %h expected 000000060000008e", {h, l}); end
    endtask

    task automatic test_flush;
        int lat, st, rv_seen; logic [31:0] h, l;
        md_if.start = 1'b1; md_if.op = MD_DIV; md_if.src_a = 32'h12345678; md_if.src_b = 32'd3;
        repeat (10) tick();
        md_if.flush = 1'b1;
        #1;
        n_checks++;
        if ({md_if.stall, md_if.result_valid} !== 2'b00) begin
            n_fail++; $display("FAIL flush_same_cycle: got stall/rv=%b expected 00", {md_if.stall, md_if.result_valid});
        end
        tick();
        md_if.flush = 1'b0; md_if.start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({md_if.busy, md_if.stall} !== 2'b00) begin
            n_fail++; $display("FAIL flush_to_idle: got busy/stall=%b expected 00", {md_if.busy, md_if.stall});
        end
        rv_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (md_if.result_valid) rv_seen++;
        end
        n_checks++; if (rv_seen !== 0) begin n_fail++; $display("FAIL flush_no_result: got %0d pulses expected 0", rv_seen); end
        n_checks++; if ({md_if.hi, md_if.lo} !== {32'd6, 32'd142}) begin n_fail++; $display("FAIL flush_hilo_kept: got %h expected 000000060000008e", {md_if.hi, md_if.lo}); end
        tick();
        run_op(MD_MULTU, 32'd5, 32'd6, 10, lat, st, h, l);
        n_checks++; if ({h, l} !== 64'd30) begin n_fail++; $display("FAIL post_flush_multu: got %h expected 000000000000001e", {h, l}); end
    endtask

    task automatic test_back_to_back;
        int lat, st; logic [31:0] h, l;
        run_op(MD_MULT, 32'd7, 32'hFFFFFFFD, 10, lat, st, h, l);
        n_checks++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFEB) begin n_fail++; $display("FAIL b2b_mult: got %h expected ffffffffffffffeb", {h, l}); end
        run_op(MD_DIVU, 32'd50, 32'd5, 40, lat, st, h, l);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_divu_latency: got %0d expected 33", lat); end
        n_checks++; if ({h, l} !== {32'd0, 32'd10}) begin n_fail++; $display("FAIL b2b_divu: got %h expected 000000000000000a", {h, l}); end
    endtask

    task automatic test_reset_mid;
        int rv_seen;
        md_if.start = 1'b1; md_if.op = MD_DIV; md_if.src_a = 32'hFFFFFF9C; md_if.src_b = 32'd7;
        repeat (5) tick();
        resetn = 1'b0; md_if.start = 1'b0;
        #1;
        n_checks++;
        if ({md_if.hi, md_if.lo} !== 64'h0) begin n_fail++; $display("FAIL reset_mid_hilo: got %h expected 0", {md_if.hi, md_if.lo}); end
        n_checks++;
        if ({md_if.busy, md_if.stall, md_if.result_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid_ctrl: got busy/stall/rv=%b expected 000", {md_if.busy, md_if.stall, md_if.result_valid});
        end
        @(negedge clk);
        resetn = 1'b1;
        rv_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (md_if.result_valid || md_if.busy) rv_seen++;
        end
        n_checks++; if (rv_seen !== 0) begin n_fail++; $display("FAIL reset_mid_no_result: got %0d active cycles expected 0", rv_seen); end
        tick();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div_signed();
        test_div_by_zero();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
